// File: rtl/dbuf_write_fifo.sv
// Elastic write buffer between the pixel pipeline and the display-buffer memory port.
// Drains over a req/ack handshake and reports frame completion after vblank.
module dbuf_write_fifo #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
) (
   input  logic              Fphi0,
   input  logic              rst_n,
   input  logic              in_we,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              vblank_in,
   input  logic              clear_ovf,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack,
   output logic [PTR_W:0]    fifo_count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              frame_done,
   output logic [15:0]       last_frame_pixels
);

   typedef enum logic [0:0] {F_RUN = 1'b0, F_DRAIN = 1'b1} frame_state_t;

   logic [ADDR_W+DATA_W-1:0] store_r [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_r;
   logic [PTR_W-1:0]         rd_ptr_r;
   logic [PTR_W:0]           count_r;
   logic [ADDR_W+DATA_W-1:0] head_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     ack_s;
   logic                     vblank_prev_r;
   logic [15:0]              pix_cnt_r;
   logic [15:0]              pix_cnt_inc_s;
   logic                     drain_done_s;
   frame_state_t             state_r;
   frame_state_t             state_s;

   assign fifo_count = count_r;
   assign full       = (count_r == (PTR_W+1)'(DEPTH));
   assign empty      = (count_r == (PTR_W+1)'(0));
   assign head_s     = store_r[rd_ptr_r];

   // Registered full gates the push, so a same-edge pop never makes room.
   assign push_s = in_we & ~full;
   assign pop_s  = (~mem_req | mem_ack) & ~empty;
   assign ack_s  = mem_req & mem_ack;
   assign pix_cnt_inc_s = (ack_s && (pix_cnt_r != 16'hFFFF)) ? (pix_cnt_r + 16'd1) : pix_cnt_r;

   // FIFO storage array, no reset needed since entries are only read when counted valid.
   always_ff @(posedge Fphi0) begin
      if (push_s) begin
         store_r[wr_ptr_r] <= {in_addr, in_data};
      end
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge Fphi0 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Output holding register and request flag.
   always_ff @(posedge Fphi0 or negedge rst_n) begin
      if (!rst_n) begin
         mem_req  <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else if (pop_s) begin
         mem_req  <= 1'b1;
         mem_addr <= head_s[ADDR_W+DATA_W-1:DATA_W];
         mem_data <= head_s[DATA_W-1:0];
      end else if (mem_ack) begin
         mem_req  <= 1'b0;
      end
   end

   // Sticky overflow; a drop on the same edge beats the clear.
   always_ff @(posedge Fphi0 or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (in_we && full) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

   // Frame state register plus vblank edge history.
   always_ff @(posedge Fphi0 or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= F_RUN;
         vblank_prev_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         vblank_prev_r <= vblank_in;
      end
   end

   // Frame next-state: drain completes once nothing is buffered or outstanding.
   always_comb begin
      state_s      = state_r;
      drain_done_s = 1'b0;
      case (state_r)
         F_RUN: begin
            if (vblank_in && !vblank_prev_r) state_s = F_DRAIN;
            else                             state_s = F_RUN;
         end
         F_DRAIN: begin
            if (empty && (!mem_req || mem_ack)) begin
               drain_done_s = 1'b1;
               state_s      = F_RUN;
            end else begin
               state_s      = F_DRAIN;
            end
         end
         default: state_s = F_RUN;
      endcase
   end

   // Pixel counter, done pulse and per-frame pixel total.
   always_ff @(posedge Fphi0 or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_r         <= 16'd0;
         frame_done        <= 1'b0;
         last_frame_pixels <= 16'd0;
      end else if (drain_done_s) begin
         pix_cnt_r         <= 16'd0;
         frame_done        <= 1'b1;
         last_frame_pixels <= pix_cnt_inc_s;
      end else begin
         pix_cnt_r         <= pix_cnt_inc_s;
         frame_done        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dbuf_write_fifo.sv
// Directed self-checking bench for dbuf_write_fifo: a vector table for the
// back-to-back drain plus hand-written multi-cycle sequences.
module tb_dbuf_write_fifo;

   logic        Fphi0 = 1'b0;
   logic        rst_n;
   logic        in_we;
   logic [15:0] in_addr;
   logic [31:0] in_data;
   logic        vblank_in;
   logic        clear_ovf;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_ack;
   logic [4:0]  fifo_count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        frame_done;
   logic [15:0] last_frame_pixels;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic        ack;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic [4:0]  exp_count;
   } vec_t;

   vec_t vecs [7];

   dbuf_write_fifo dut (
      .Fphi0(Fphi0), .rst_n(rst_n), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
      .vblank_in(vblank_in), .clear_ovf(clear_ovf), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ack(mem_ack), .fifo_count(fifo_count), .full(full),
      .empty(empty), .overflow(overflow), .frame_done(frame_done),
      .last_frame_pixels(last_frame_pixels)
   );

   always #5 Fphi0 = ~Fphi0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Fphi0);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_we = 1'b0; in_addr = 16'd0; in_data = 32'd0;
      vblank_in = 1'b0; clear_ovf = 1'b0; mem_ack = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [15:0] a);
      in_we = 1'b1; in_addr = a; in_data = 32'h00AA0000 + {16'd0, a};
      step();
      in_we = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 5'd1};
      vecs[1] = '{1'b1, 16'd1, 1'b1, 1'b1, 16'd0, 5'd1};
      vecs[2] = '{1'b1, 16'd2, 1'b1, 1'b1, 16'd1, 5'd1};
      vecs[3] = '{1'b1, 16'd3, 1'b1, 1'b1, 16'd2, 5'd1};
      vecs[4] = '{1'b1, 16'd4, 1'b1, 1'b1, 16'd3, 5'd1};
      vecs[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd4, 5'd0};
      vecs[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 5'd0};

      // Reset state
      do_reset();
      chk("rst_req", mem_req, 1'b0);
      chk("rst_count", fifo_count, 5'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_addr", mem_addr, 16'd0);
      chk("rst_data", mem_data, 32'd0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      chk("rst_lfp", last_frame_pixels, 16'd0);

      // Fill with memory stalled
      for (int i = 0; i < 17; i++) begin
         push(16'(i));
         if (i == 15) begin
            chk("fill_count16", fifo_count, 5'd15);
            chk("fill_full16", full, 1'b0);
         end
      end
      chk("fill_full17", full, 1'b1);
      chk("fill_count17", fifo_count, 5'd16);
      chk("fill_req", mem_req, 1'b1);
      chk("fill_addr_held", mem_addr, 16'd0);
      chk("fill_data_held", mem_data, 32'h00AA0000);
      push(16'd17);
      chk("drop_ovf", overflow, 1'b1);
      chk("drop_count", fifo_count, 5'd16);
      step();
      chk("ovf_sticky", overflow, 1'b1);

      // Back-to-back drain, table driven
      do_reset();
      for (int i = 0; i < 7; i++) begin
         in_we = vecs[i].we; in_addr = vecs[i].addr;
         in_data = 32'h00AA0000 + {16'd0, vecs[i].addr};
         mem_ack = vecs[i].ack;
         step();
         chk($sformatf("b2b_req[%0d]", i), mem_req, vecs[i].exp_req);
         chk($sformatf("b2b_count[%0d]", i), fifo_count, vecs[i].exp_count);
         if (vecs[i].exp_req) begin
            chk($sformatf("b2b_addr[%0d]", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("b2b_data[%0d]", i), mem_data, 32'h00AA0000 + {16'd0, vecs[i].exp_addr});
         end
      end
      in_we = 1'b0; mem_ack = 1'b0;

      // Frame drain with ack every other cycle
      do_reset();
      push(16'd0); push(16'd1); push(16'd2);
      chk("fr_count", fifo_count, 5'd2);
      vblank_in = 1'b1; step();
      vblank_in = 1'b0; mem_ack = 1'b1; step();
      chk("fr_fd_a", frame_done, 1'b0);
      vblank_in = 1'b1; mem_ack = 1'b0; step();
      chk("fr_fd_b", frame_done, 1'b0);
      mem_ack = 1'b1; step();
      chk("fr_fd_c", frame_done, 1'b0);
      chk("fr_empty", empty, 1'b1);
      mem_ack = 1'b0; step();
      chk("fr_fd_d", frame_done, 1'b0);
      mem_ack = 1'b1; step();
      chk("fr_fd_pulse", frame_done, 1'b1);
      chk("fr_lfp", last_frame_pixels, 16'd3);
      chk("fr_req_off", mem_req, 1'b0);
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("fr_no_second[%0d]", i), frame_done, 1'b0);
      end
      vblank_in = 1'b0; step();
      vblank_in = 1'b1; step();
      step();
      chk("fr2_pulse", frame_done, 1'b1);
      chk("fr2_lfp", last_frame_pixels, 16'd0);
      vblank_in = 1'b0;

      // Reset mid-transaction
      do_reset();
      for (int i = 0; i < 7; i++) push(16'(i));
      chk("mid_count", fifo_count, 5'd6);
      chk("mid_req", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", mem_req, 1'b0);
      chk("arst_count", fifo_count, 5'd0);
      chk("arst_empty", empty, 1'b1);
      step();
      rst_n = 1'b1;

      // Simultaneous push and pop, then order check
      do_reset();
      for (int i = 0; i < 9; i++) push(16'(i));
      chk("pp_count_pre", fifo_count, 5'd8);
      mem_ack = 1'b1;
      push(16'd9);
      chk("pp_count", fifo_count, 5'd8);
      chk("pp_addr", mem_addr, 16'd1);
      for (int i = 2; i < 10; i++) begin
         step();
         chk($sformatf("pp_order[%0d]", i), mem_addr, 16'(i));
      end
      chk("pp_empty", empty, 1'b1);
      mem_ack = 1'b0;

      // Overflow set beats clear
      do_reset();
      for (int i = 0; i < 17; i++) push(16'(i));
      chk("oc_full", full, 1'b1);
      chk("oc_ovf_pre", overflow, 1'b0);
      clear_ovf = 1'b1;
      push(16'd99);
      chk("oc_set_wins", overflow, 1'b1);
      step();
      chk("oc_cleared", overflow, 1'b0);
      clear_ovf = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
